// File: rtl/ldpc_cnu_serial.sv
// Serial offset-min-sum check node unit: collects ROW_WEIGHT v2c LLRs, then replays
// ROW_WEIGHT c2v LLRs in the same order and reports the row's hard-decision parity.
module ldpc_cnu_serial #(
  parameter int unsigned ROW_WEIGHT = 24,
  parameter int unsigned LLR_WIDTH  = 8,
  parameter int unsigned OFFSET     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LLR_WIDTH-1:0] in_llr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LLR_WIDTH-1:0] out_llr,
  output logic                 out_last,
  output logic                 parity_ok
);

  localparam int unsigned CW = (ROW_WEIGHT > 1) ? $clog2(ROW_WEIGHT) : 1;
  localparam int unsigned MW = LLR_WIDTH - 1;
  localparam logic [MW-1:0] MagMax  = '1;
  localparam logic [CW-1:0] LastIdx = CW'(ROW_WEIGHT - 1);

  typedef enum logic {StIn, StOut} state_e;

  state_e                  r_state_q, w_state_d;
  logic [CW-1:0]           r_cnt_q, w_cnt_d;
  logic [MW-1:0]           r_min1_q, w_min1_d;
  logic [MW-1:0]           r_min2_q, w_min2_d;
  logic [CW-1:0]           r_idx_q, w_idx_d;
  logic [ROW_WEIGHT-1:0]   r_sign_q, w_sign_d;
  logic                    r_sign_prod_q, w_sign_prod_d;
  logic                    r_parity_q, w_parity_d;
  logic [LLR_WIDTH-1:0]    r_out_llr_q, w_out_llr_d;
  logic                    r_out_last_q, w_out_last_d;

  logic                    w_in_sign;
  logic [LLR_WIDTH-1:0]    w_in_neg;
  logic [MW-1:0]           w_in_mag;
  logic [MW-1:0]           w_sel;
  logic [MW-1:0]           w_mag_off;
  logic                    w_out_sign;
  logic [LLR_WIDTH-1:0]    w_out_abs;
  logic [LLR_WIDTH-1:0]    w_out_val;

  // Magnitude of the incoming LLR; the most negative code wraps on negation, so saturate it.
  always_comb begin
    w_in_sign = in_llr[LLR_WIDTH-1];
    w_in_neg  = -in_llr;
    if (w_in_sign) begin
      w_in_mag = w_in_neg[LLR_WIDTH-1] ? MagMax : w_in_neg[MW-1:0];
    end else begin
      w_in_mag = in_llr[MW-1:0];
    end
  end

  always_comb begin
    w_state_d     = r_state_q;
    w_cnt_d       = r_cnt_q;
    w_min1_d      = r_min1_q;
    w_min2_d      = r_min2_q;
    w_idx_d       = r_idx_q;
    w_sign_d      = r_sign_q;
    w_sign_prod_d = r_sign_prod_q;
    w_parity_d    = r_parity_q;
    unique case (r_state_q)
      StIn: begin
        if (in_valid) begin
          w_sign_d[r_cnt_q] = w_in_sign;
          w_sign_prod_d     = r_sign_prod_q ^ w_in_sign;
          if (w_in_mag < r_min1_q) begin
            w_min2_d = r_min1_q;
            w_min1_d = w_in_mag;
            w_idx_d  = r_cnt_q;
          end else if (w_in_mag < r_min2_q) begin
            w_min2_d = w_in_mag;
          end
          if (r_cnt_q == LastIdx) begin
            w_cnt_d    = '0;
            w_state_d  = StOut;
            w_parity_d = ~w_sign_prod_d;
          end else begin
            w_cnt_d = r_cnt_q + 1'b1;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          if (r_cnt_q == LastIdx) begin
            w_cnt_d       = '0;
            w_state_d     = StIn;
            w_min1_d      = MagMax;
            w_min2_d      = MagMax;
            w_idx_d       = '0;
            w_sign_d      = '0;
            w_sign_prod_d = 1'b0;
          end else begin
            w_cnt_d = r_cnt_q + 1'b1;
          end
        end
      end
      default: w_state_d = StIn;
    endcase
  end

  // Output word is formed from next-state values so it is ready on the cycle out_valid rises.
  always_comb begin
    w_sel = (w_cnt_d == w_idx_d) ? w_min2_d : w_min1_d;
    if (32'(w_sel) > OFFSET) begin
      w_mag_off = w_sel - MW'(OFFSET);
    end else begin
      w_mag_off = '0;
    end
    w_out_sign = w_sign_prod_d ^ w_sign_d[w_cnt_d];
    w_out_abs  = {1'b0, w_mag_off};
    w_out_val  = w_out_sign ? -w_out_abs : w_out_abs;
    if (w_state_d == StOut) begin
      w_out_llr_d  = w_out_val;
      w_out_last_d = (w_cnt_d == LastIdx);
    end else begin
      w_out_llr_d  = '0;
      w_out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q     <= StIn;
      r_cnt_q       <= '0;
      r_min1_q      <= MagMax;
      r_min2_q      <= MagMax;
      r_idx_q       <= '0;
      r_sign_q      <= '0;
      r_sign_prod_q <= 1'b0;
      r_parity_q    <= 1'b0;
      r_out_llr_q   <= '0;
      r_out_last_q  <= 1'b0;
    end else begin
      r_state_q     <= w_state_d;
      r_cnt_q       <= w_cnt_d;
      r_min1_q      <= w_min1_d;
      r_min2_q      <= w_min2_d;
      r_idx_q       <= w_idx_d;
      r_sign_q      <= w_sign_d;
      r_sign_prod_q <= w_sign_prod_d;
      r_parity_q    <= w_parity_d;
      r_out_llr_q   <= w_out_llr_d;
      r_out_last_q  <= w_out_last_d;
    end
  end

  assign in_ready  = (r_state_q == StIn);
  assign out_valid = (r_state_q == StOut);
  assign out_llr   = r_out_llr_q;
  assign out_last  = r_out_last_q;
  assign parity_ok = r_parity_q;

endmodule

// File: tb/tb_ldpc_cnu_serial.sv
// Directed bench: three units (OFFSET 0, 1, 4) share one stimulus stream, ROW_WEIGHT=4.
module tb_ldpc_cnu_serial;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_llr;
  logic       out_ready;

  logic       in_ready0, in_ready1, in_ready4;
  logic       out_valid0, out_valid1, out_valid4;
  logic [7:0] out_llr0, out_llr1, out_llr4;
  logic       out_last0, out_last1, out_last4;
  logic       parity0, parity1, parity4;

  int total = 0;
  int bad   = 0;

  ldpc_cnu_serial #(.ROW_WEIGHT(4), .LLR_WIDTH(8), .OFFSET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_llr(in_llr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_llr(out_llr0), .out_last(out_last0),
    .parity_ok(parity0)
  );
  ldpc_cnu_serial #(.ROW_WEIGHT(4), .LLR_WIDTH(8), .OFFSET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_llr(in_llr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_llr(out_llr1), .out_last(out_last1),
    .parity_ok(parity1)
  );
  ldpc_cnu_serial #(.ROW_WEIGHT(4), .LLR_WIDTH(8), .OFFSET(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_llr(in_llr),
    .out_valid(out_valid4), .out_ready(out_ready), .out_llr(out_llr4), .out_last(out_last4),
    .parity_ok(parity4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " in_ready0"}, {7'd0, in_ready0}, 8'd1);
    chk({tag, " in_ready4"}, {7'd0, in_ready4}, 8'd1);
    chk({tag, " out_valid0"}, {7'd0, out_valid0}, 8'd0);
    chk({tag, " out_llr0"}, out_llr0, 8'd0);
    chk({tag, " out_llr1"}, out_llr1, 8'd0);
    chk({tag, " out_last0"}, {7'd0, out_last0}, 8'd0);
    chk({tag, " parity0"}, {7'd0, parity0}, 8'd0);
    chk({tag, " parity4"}, {7'd0, parity4}, 8'd0);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push(input logic [7:0] v, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_llr   = v;
    chk("in_ready", {7'd0, in_ready0}, 8'd1);
    chk("out_valid_in", {7'd0, out_valid0}, 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic row_in(input logic [31:0] r, input int gap_max, input logic p);
    for (int i = 0; i < 4; i++) begin
      push(r[31-8*i -: 8], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
    chk("parity0", {7'd0, parity0}, {7'd0, p});
    chk("parity1", {7'd0, parity1}, {7'd0, p});
    chk("parity4", {7'd0, parity4}, {7'd0, p});
  endtask

  task automatic pull(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e4,
                      input int stall_max, input int count);
    int st;
    for (int j = 0; j < count; j++) begin
      st = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      out_ready = 1'b0;
      for (int k = 0; k < st; k++) begin
        @(negedge clk);
        chk("hold_llr0", out_llr0, e0[31-8*j -: 8]);
        chk("hold_llr4", out_llr4, e4[31-8*j -: 8]);
        chk("hold_in_ready", {7'd0, in_ready0}, 8'd0);
      end
      out_ready = 1'b1;
      chk("out_valid", {7'd0, out_valid0}, 8'd1);
      chk("in_ready_out", {7'd0, in_ready1}, 8'd0);
      chk("out_llr0", out_llr0, e0[31-8*j -: 8]);
      chk("out_llr1", out_llr1, e1[31-8*j -: 8]);
      chk("out_llr4", out_llr4, e4[31-8*j -: 8]);
      chk("out_last0", {7'd0, out_last0}, (j == 3) ? 8'd1 : 8'd0);
      chk("out_last4", {7'd0, out_last4}, (j == 3) ? 8'd1 : 8'd0);
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  localparam logic [31:0] R1  = {8'sd10, -8'sd3, 8'sd7, -8'sd5};
  localparam logic [31:0] E10 = {8'sd3, -8'sd5, 8'sd3, -8'sd3};
  localparam logic [31:0] E11 = {8'sd2, -8'sd4, 8'sd2, -8'sd2};
  localparam logic [31:0] E14 = {8'sd0, -8'sd1, 8'sd0, 8'sd0};
  localparam logic [31:0] R3  = {8'h80, 8'h80, 8'sd127, 8'sd1};
  localparam logic [31:0] E30 = {-8'sd1, -8'sd1, 8'sd1, 8'sd127};
  localparam logic [31:0] E31 = {8'sd0, 8'sd0, 8'sd0, 8'sd126};
  localparam logic [31:0] E34 = {8'sd0, 8'sd0, 8'sd0, 8'sd123};
  localparam logic [31:0] R4  = {8'sd4, -8'sd4, 8'sd4, 8'sd4};
  localparam logic [31:0] E40 = {-8'sd4, 8'sd4, -8'sd4, -8'sd4};
  localparam logic [31:0] E41 = {-8'sd3, 8'sd3, -8'sd3, -8'sd3};
  localparam logic [31:0] E44 = {8'sd0, 8'sd0, 8'sd0, 8'sd0};
  localparam logic [31:0] R5  = {-8'sd1, 8'sd2, -8'sd3, 8'sd4};
  localparam logic [31:0] E50 = {-8'sd2, 8'sd1, -8'sd1, 8'sd1};
  localparam logic [31:0] E51 = {-8'sd1, 8'sd0, 8'sd0, 8'sd0};
  localparam logic [31:0] E54 = {8'sd0, 8'sd0, 8'sd0, 8'sd0};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_llr    = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {7'd0, in_ready0}, 8'd1);

    // Basic rows, no gaps or stalls.
    row_in(R1, 0, 1'b1);
    pull(E10, E11, E14, 0, 4);
    chk("back_in_ready", {7'd0, in_ready0}, 8'd1);
    chk("back_out_valid", {7'd0, out_valid0}, 8'd0);
    chk("parity_held", {7'd0, parity0}, 8'd1);
    row_in(R3, 0, 1'b1);
    pull(E30, E31, E34, 0, 4);
    row_in(R4, 0, 1'b0);
    pull(E40, E41, E44, 0, 4);

    // Back-to-back rows with input gaps and output stalls.
    row_in(R5, 2, 1'b1);
    pull(E50, E51, E54, 3, 4);
    row_in(R1, 2, 1'b1);
    pull(E10, E11, E14, 3, 4);
    row_in(R4, 3, 1'b0);
    pull(E40, E41, E44, 2, 4);
    row_in(R3, 1, 1'b1);
    pull(E30, E31, E34, 3, 4);

    // Reset after two inputs.
    push(R4[31:24], 0);
    push(R4[23:16], 0);
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_in");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-output.
    row_in(R1, 0, 1'b1);
    pull(E10, E11, E14, 1, 2);
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_out");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    row_in(R1, 1, 1'b1);
    pull(E10, E11, E14, 2, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
